// File: rtl/shop_item_ctrl.sv
// Item-table controller: linear scan of a small name/owner/stock table,
// then one read-modify-write for ADD, DEL or BUY. Fixed latency per request.
module shop_item_ctrl #(
  parameter int MAX_ITEMS  = 8,
  parameter int IDX_BITS   = 3,
  parameter int NAME_BITS  = 64,
  parameter int USER_BITS  = 4,
  parameter int STOCK_BITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic [1:0]            i_op,
  input  logic [USER_BITS-1:0]  i_user,
  input  logic [NAME_BITS-1:0]  i_name,
  input  logic [STOCK_BITS-1:0] i_stock,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [3:0]            o_status,
  output logic [STOCK_BITS-1:0] o_stock_left,
  output logic [IDX_BITS:0]     o_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_DEL = 2'b01;
  localparam logic [1:0] OP_BUY = 2'b10;

  localparam logic [3:0] ST_NONE      = 4'd0;
  localparam logic [3:0] ST_ADDED     = 4'd1;
  localparam logic [3:0] ST_EXISTS    = 4'd2;
  localparam logic [3:0] ST_FULL      = 4'd3;
  localparam logic [3:0] ST_DELETED   = 4'd4;
  localparam logic [3:0] ST_UNKNOWN   = 4'd5;
  localparam logic [3:0] ST_NOT_YOURS = 4'd6;
  localparam logic [3:0] ST_BOUGHT    = 4'd7;
  localparam logic [3:0] ST_NO_STOCK  = 4'd8;
  localparam logic [3:0] ST_BAD_OP    = 4'd9;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(MAX_ITEMS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]            op;
    logic [USER_BITS-1:0]  user;
    logic [NAME_BITS-1:0]  name;
    logic [STOCK_BITS-1:0] stock;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q, req_d;

  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                match_hit_q, match_hit_d;
  logic [IDX_BITS-1:0] match_idx_q, match_idx_d;
  logic                free_hit_q, free_hit_d;
  logic [IDX_BITS-1:0] free_idx_q, free_idx_d;

  logic [MAX_ITEMS-1:0]                 valid_q, valid_d;
  logic [MAX_ITEMS-1:0][NAME_BITS-1:0]  name_q, name_d;
  logic [MAX_ITEMS-1:0][USER_BITS-1:0]  owner_q, owner_d;
  logic [MAX_ITEMS-1:0][STOCK_BITS-1:0] stock_q, stock_d;

  logic [3:0]            status_q, status_d;
  logic [STOCK_BITS-1:0] stock_left_q, stock_left_d;
  logic [IDX_BITS:0]     count_q, count_d;

  // State register; reset aborts any in-flight request with no table write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      idx_q        <= '0;
      match_hit_q  <= 1'b0;
      match_idx_q  <= '0;
      free_hit_q   <= 1'b0;
      free_idx_q   <= '0;
      valid_q      <= '0;
      name_q       <= '0;
      owner_q      <= '0;
      stock_q      <= '0;
      status_q     <= ST_NONE;
      stock_left_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      idx_q        <= idx_d;
      match_hit_q  <= match_hit_d;
      match_idx_q  <= match_idx_d;
      free_hit_q   <= free_hit_d;
      free_idx_q   <= free_idx_d;
      valid_q      <= valid_d;
      name_q       <= name_d;
      owner_q      <= owner_d;
      stock_q      <= stock_d;
      status_q     <= status_d;
      stock_left_q <= stock_left_d;
      count_q      <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_req) state_d = S_SCAN;
      S_SCAN: if (idx_q == LAST_IDX) state_d = S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch, scan, then a single decision/write in EXEC
  always_comb begin
    req_d        = req_q;
    idx_d        = idx_q;
    match_hit_d  = match_hit_q;
    match_idx_d  = match_idx_q;
    free_hit_d   = free_hit_q;
    free_idx_d   = free_idx_q;
    valid_d      = valid_q;
    name_d       = name_q;
    owner_d      = owner_q;
    stock_d      = stock_q;
    status_d     = status_q;
    stock_left_d = stock_left_q;
    count_d      = count_q;

    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          req_d       = '{op: i_op, user: i_user, name: i_name, stock: i_stock};
          idx_d       = '0;
          match_hit_d = 1'b0;
          match_idx_d = '0;
          free_hit_d  = 1'b0;
          free_idx_d  = '0;
        end
      end
      S_SCAN: begin
        // Every slot is visited even after a hit so latency never varies.
        if (valid_q[idx_q] && (name_q[idx_q] == req_q.name) && !match_hit_q) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!valid_q[idx_q] && !free_hit_q) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
      end
      S_EXEC: begin
        status_d     = ST_NONE;
        stock_left_d = '0;
        case (req_q.op)
          OP_ADD: begin
            if (match_hit_q) begin
              status_d     = ST_EXISTS;
              stock_left_d = stock_q[match_idx_q];
            end else if (!free_hit_q) begin
              status_d = ST_FULL;
            end else begin
              valid_d[free_idx_q] = 1'b1;
              name_d[free_idx_q]  = req_q.name;
              owner_d[free_idx_q] = req_q.user;
              stock_d[free_idx_q] = req_q.stock;
              status_d            = ST_ADDED;
              stock_left_d        = req_q.stock;
              count_d             = count_q + 1'b1;
            end
          end
          OP_DEL: begin
            if (!match_hit_q) begin
              status_d = ST_UNKNOWN;
            end else if ((owner_q[match_idx_q] != req_q.user) && (req_q.user != '0)) begin
              status_d = ST_NOT_YOURS;
            end else begin
              valid_d[match_idx_q] = 1'b0;
              status_d             = ST_DELETED;
              count_d              = count_q - 1'b1;
            end
          end
          OP_BUY: begin
            if (!match_hit_q) begin
              status_d = ST_UNKNOWN;
            end else if (stock_q[match_idx_q] == '0) begin
              status_d = ST_NO_STOCK;
            end else begin
              stock_d[match_idx_q] = stock_q[match_idx_q] - 1'b1;
              status_d             = ST_BOUGHT;
              stock_left_d         = stock_q[match_idx_q] - 1'b1;
            end
          end
          default: status_d = ST_BAD_OP;
        endcase
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy       = (state_q != S_IDLE);
    o_done       = (state_q == S_DONE);
    o_status     = status_q;
    o_stock_left = stock_left_q;
    o_count      = count_q;
  end

endmodule

// File: doc/shop_item_ctrl.md
# shop_item_ctrl

Item-table controller for the shop command engine. It owns a small on-chip item table (name, owner, stock) and sequences every add, delete and buy request from the command FSM. Each request is handled as a linear search followed by a single read-modify-write. The command FSM turns the returned status code into its ASCII response ("ItmAdded", "ItmExists", "ItmsFull", "ItmUnknwn", "NtYourItm", "ItmDeletd", "NoStock", "ItmBought").

## Interface
- MAX_ITEMS, 8: table depth; power of two, 2..16.
- IDX_BITS, 3: log2(MAX_ITEMS).
- NAME_BITS, 64: item name width, 8 ASCII chars.
- USER_BITS, 4: user number width; user 0 is admin.
- STOCK_BITS, 8: stock counter width.
- Ports use one clock and one reset. Reset is asynchronous and active-high.
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  1  request strobe; sampled only while o_busy=0.
- i_op  in  2  operation: 00 ADD, 01 DEL, 10 BUY, 11 reserved.
- i_user  in  USER_BITS  requesting user number.
- i_name  in  NAME_BITS  item name.
- i_stock  in  STOCK_BITS  initial stock; used by ADD only.
- o_busy  out  1  high from the cycle after accept through the o_done cycle.
- o_done  out  1  one-cycle completion pulse.
- o_status  out  4  result code; held until the next o_done.
- o_stock_left  out  STOCK_BITS  stock of the affected entry after the operation; 0 when no entry is affected.
- o_count  out  IDX_BITS+1  number of valid entries.

## Operation
- Table entry fields: valid, name, owner (USER_BITS), stock. All entries are internal registers.
- Status codes:
  - 0 NONE
  - 1 ADDED
  - 2 EXISTS
  - 3 FULL
  - 4 DELETED
  - 5 UNKNOWN
  - 6 NOT_YOURS
  - 7 BOUGHT
  - 8 NO_STOCK
  - 9 BAD_OP
- IDLE: i_req=1 latches i_op, i_user, i_name and i_stock. Clears match_hit and free_hit. Sets idx=0. Next state is SCAN.
- SCAN: one entry per cycle at idx.
  - A valid entry with name equal to the latched name, when match_hit=0, records match_idx and sets match_hit.
  - An invalid entry, when free_hit=0, records free_idx and sets free_hit.
  - Every entry is examined, even after a hit: fixed latency.
  - Leaves for EXEC after idx=MAX_ITEMS-1.
- EXEC: single decision and write.
  - ADD: match_hit gives EXISTS. Otherwise free_hit=0 gives FULL. Otherwise write free_idx with {1, name, user, stock} and report ADDED. i_stock=0 is legal.
  - DEL: match_hit=0 gives UNKNOWN. owner≠user with user≠0 gives NOT_YOURS. Otherwise clear valid and report DELETED.
  - BUY: match_hit=0 gives UNKNOWN. stock=0 gives NO_STOCK. Otherwise stock−1 and report BOUGHT. An owner may buy its own item. Stock never wraps below 0.
  - op 11: BAD_OP, table unchanged.
  - o_stock_left values:
    - ADDED: new stock.
    - BOUGHT: decremented stock.
    - NO_STOCK: 0.
    - EXISTS: existing entry's stock.
    - All other codes: 0.
- DONE: o_done=1, o_status and o_stock_left are valid. Next state is IDLE.
- o_count is incremented on ADDED and decremented on DELETED, in the same edge as the table write.
- Only the first matching entry counts. Duplicate names cannot arise, since ADD rejects them.

## Timing
- Accept edge k means i_req=1 in IDLE.
  - SCAN occupies the MAX_ITEMS cycles after edge k.
  - EXEC occupies cycle k+MAX_ITEMS+1.
  - DONE occupies cycle k+MAX_ITEMS+2.
  - The default configuration takes 10 cycles from the accept edge to o_done.
- The table write, o_count, o_status and o_stock_left all update on the EXEC→DONE edge, so they are visible in the o_done cycle.
- i_req during SCAN, EXEC or DONE is ignored, not queued. The earliest next accept is the cycle after o_done, so back-to-back requests issue every MAX_ITEMS+3 cycles.
- Request inputs are don't-care after the accept edge.
- Reset, asynchronous at any time:
  - state goes to IDLE and every entry's valid bit to 0.
  - o_busy, o_done, o_status, o_stock_left and o_count go to 0.
  - An in-flight operation is aborted with no write and no o_done.
- i_req high while i_reset is high is ignored. The first accept is possible on the first edge after reset deasserts.

## Test plan
- Reset, then ADD "Laptop" user 2 stock 3 -> o_done 10 cycles after accept, status 1, o_stock_left 3, o_count 1.
- Repeat the same ADD -> status 2, o_stock_left 3, o_count stays 1. Then BUY "Laptop" user 3 three times -> status 7 with o_stock_left 2, 1, 0. A fourth BUY -> status 8, stock stays 0.
- DEL "Laptop" by user 3 -> status 6. DEL by user 0 -> status 4, o_count 0. BUY "Laptop" -> status 5.
- ADD 8 distinct names -> o_count 8. A ninth ADD -> status 3. DEL entry 4, then ADD a new name -> status 1, reusing the freed slot. o_count returns to 8.
- Hold i_req high continuously -> requests are accepted every 11 cycles. o_busy is never low in a cycle where a request is accepted mid-operation. op 11 -> status 9, table unchanged.
- Assert i_reset 4 cycles into an ADD scan -> no o_done, o_count 0. A following BUY of that name -> status 5.
